// File: rtl/axis_packet_dispatcher_fsm.sv
// Sequencing controller for the AXIS packet dispatcher: steers header beats to the parser,
// waits for a forward/drop verdict (with timeout), then forwards or discards the rest of the packet.
module axis_packet_dispatcher_fsm #(
  parameter int STATE_WIDTH     = 3,
  parameter int PARSE_BEATS     = 2,
  parameter int CONTROL_TIMEOUT = 16,
  parameter int STAT_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [STATE_WIDTH-1:0] state,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic                   parser_tvalid,
  input  logic                   parser_tready,
  output logic                   parser_tlast,
  input  logic                   parser_result_valid,
  input  logic                   parser_result_drop,
  input  logic                   s_analysed_tvalid,
  output logic                   s_analysed_tready,
  input  logic                   s_analysed_tlast,
  output logic                   m_axis_mux_tvalid,
  input  logic                   m_axis_mux_tready,
  output logic                   m_axis_mux_tlast,
  output logic [STAT_WIDTH-1:0]  stat_pkt_count,
  output logic [STAT_WIDTH-1:0]  stat_drop_count,
  output logic                   stat_timeout
);

  localparam int BEAT_W = (PARSE_BEATS < 2) ? 1 : $clog2(PARSE_BEATS + 1);
  localparam int TO_W   = (CONTROL_TIMEOUT < 2) ? 1 : $clog2(CONTROL_TIMEOUT + 1);

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE               = STATE_WIDTH'(0),
    PARSE_DATA         = STATE_WIDTH'(1),
    CONTROL            = STATE_WIDTH'(2),
    SEND_ANALYSED_DATA = STATE_WIDTH'(3),
    SEND_REMAIN        = STATE_WIDTH'(4),
    DROP               = STATE_WIDTH'(5)
  } state_t;

  state_t            state_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic [TO_W-1:0]   timeout_cnt;
  logic              pkt_ended;

  logic last_hdr_beat;
  logic ctl_expired;
  logic in_fire;
  logic hdr_fire;
  logic an_fire;

  assign state         = state_q;
  assign last_hdr_beat = (beat_cnt == BEAT_W'(PARSE_BEATS - 1));
  assign ctl_expired   = (timeout_cnt == TO_W'(CONTROL_TIMEOUT - 1));
  assign in_fire       = s_axis_tvalid & s_axis_tready;
  assign hdr_fire      = parser_tvalid & parser_tready;
  assign an_fire       = s_analysed_tvalid & s_analysed_tready;

  // Handshakes are combinational so a beat moves in the same cycle its path is selected.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    s_axis_tready     = 1'b0;
    parser_tvalid     = 1'b0;
    parser_tlast      = 1'b0;
    s_analysed_tready = 1'b0;
    m_axis_mux_tvalid = 1'b0;
    m_axis_mux_tlast  = 1'b0;
    unique case (state_q)
      PARSE_DATA: begin
        parser_tvalid = s_axis_tvalid;
        s_axis_tready = parser_tready;
        parser_tlast  = s_axis_tlast | last_hdr_beat;
      end
      SEND_ANALYSED_DATA: begin
        m_axis_mux_tvalid = s_analysed_tvalid;
        s_analysed_tready = m_axis_mux_tready;
        m_axis_mux_tlast  = s_analysed_tlast & pkt_ended;
      end
      SEND_REMAIN: begin
        m_axis_mux_tvalid = s_axis_tvalid;
        s_axis_tready     = m_axis_mux_tready;
        m_axis_mux_tlast  = s_axis_tlast;
      end
      DROP: s_axis_tready = 1'b1;
      default: ;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      beat_cnt        <= '0;
      timeout_cnt     <= '0;
      pkt_ended       <= 1'b0;
      stat_pkt_count  <= '0;
      stat_drop_count <= '0;
      stat_timeout    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s_axis_tvalid) begin
            state_q   <= PARSE_DATA;
            beat_cnt  <= '0;
            pkt_ended <= 1'b0;
          end
        end
        PARSE_DATA: begin
          if (hdr_fire) begin
            beat_cnt  <= beat_cnt + BEAT_W'(1);
            pkt_ended <= s_axis_tlast;
            if (parser_tlast) begin
              state_q     <= CONTROL;
              timeout_cnt <= '0;
            end
          end
        end
        CONTROL: begin
          timeout_cnt <= timeout_cnt + TO_W'(1);
          // A verdict arriving on the expiry cycle takes priority over the timeout.
          if (parser_result_valid && !parser_result_drop) begin
            state_q <= SEND_ANALYSED_DATA;
          end else if (parser_result_valid || ctl_expired) begin
            state_q         <= pkt_ended ? IDLE : DROP;
            stat_drop_count <= stat_drop_count + STAT_WIDTH'(1);
            if (!parser_result_valid) stat_timeout <= 1'b1;
          end
        end
        SEND_ANALYSED_DATA: begin
          if (an_fire && s_analysed_tlast) begin
            if (pkt_ended) begin
              state_q        <= IDLE;
              stat_pkt_count <= stat_pkt_count + STAT_WIDTH'(1);
            end else begin
              state_q <= SEND_REMAIN;
            end
          end
        end
        SEND_REMAIN: begin
          if (in_fire && s_axis_tlast) begin
            state_q        <= IDLE;
            stat_pkt_count <= stat_pkt_count + STAT_WIDTH'(1);
          end
        end
        DROP: begin
          if (in_fire && s_axis_tlast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_dispatcher_fsm.sv
// Self-checking bench for axis_packet_dispatcher_fsm: directed scenarios plus randomized
// throttled traffic scored against a packet-level reference model.
module tb_axis_packet_dispatcher_fsm;

  localparam int PB = 2;
  localparam int CT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic        parser_tvalid, parser_tready, parser_tlast;
  logic        parser_result_valid, parser_result_drop;
  logic        s_analysed_tvalid, s_analysed_tready, s_analysed_tlast;
  logic        m_axis_mux_tvalid, m_axis_mux_tready, m_axis_mux_tlast;
  logic [31:0] stat_pkt_count, stat_drop_count;
  logic        stat_timeout;

  always #5 clk = ~clk;

  axis_packet_dispatcher_fsm #(
    .STATE_WIDTH(3), .PARSE_BEATS(PB), .CONTROL_TIMEOUT(CT), .STAT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .state(state),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .parser_tvalid(parser_tvalid), .parser_tready(parser_tready), .parser_tlast(parser_tlast),
    .parser_result_valid(parser_result_valid), .parser_result_drop(parser_result_drop),
    .s_analysed_tvalid(s_analysed_tvalid), .s_analysed_tready(s_analysed_tready),
    .s_analysed_tlast(s_analysed_tlast),
    .m_axis_mux_tvalid(m_axis_mux_tvalid), .m_axis_mux_tready(m_axis_mux_tready),
    .m_axis_mux_tlast(m_axis_mux_tlast),
    .stat_pkt_count(stat_pkt_count), .stat_drop_count(stat_drop_count),
    .stat_timeout(stat_timeout)
  );

  typedef struct {logic [31:0] data; logic last;} beat_t;
  typedef struct {bit fwd; bit never; int delay; int n_an;} desc_t;

  beat_t src_q[$], an_q[$], exp_q[$], obs_q[$];
  desc_t desc_q[$];
  int    trace[$];

  logic [31:0] s_data, an_data, hdr_sum, an_base;
  int          p_src, p_ptr, p_mux;
  bit          v_pend, v_drop;
  int          v_wait, an_n;
  int          exp_pkt, exp_drop, drop_beats;
  bit          exp_timeout, any_mux_valid;
  int          errors = 0;
  int          checks = 0;

  // Reference model: a packet's outcome is derived from its descriptor alone.
  task automatic add_packet(int n, bit fwd, int delay, bit never, int n_an);
    logic [31:0] d[];
    logic [31:0] sum;
    bit honoured;
    sum = '0;
    d = new[n];
    for (int i = 0; i < n; i++) begin
      d[i] = $urandom;
      src_q.push_back(beat_t'{d[i], (i == n - 1)});
      if (i < PB) sum = sum + d[i];
    end
    desc_q.push_back(desc_t'{fwd, never, delay, n_an});
    honoured = !never && (delay < CT);
    if (!honoured) begin
      exp_drop++;
      exp_timeout = 1'b1;
    end else if (fwd) begin
      for (int i = 0; i < n_an; i++)
        exp_q.push_back(beat_t'{sum ^ (32'(i) << 28), (i == n_an - 1) && (n <= PB)});
      for (int k = PB; k < n; k++) exp_q.push_back(beat_t'{d[k], (k == n - 1)});
      exp_pkt++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_data = '0;
    parser_tready = 0; parser_result_valid = 0; parser_result_drop = 0;
    s_analysed_tvalid = 0; s_analysed_tlast = 0; an_data = '0;
    m_axis_mux_tready = 0;
    src_q.delete(); an_q.delete(); exp_q.delete(); obs_q.delete(); desc_q.delete();
    trace.delete();
    v_pend = 0; v_drop = 0; v_wait = 0; hdr_sum = '0; an_base = '0; an_n = 0;
    exp_pkt = 0; exp_drop = 0; exp_timeout = 0; drop_beats = 0; any_mux_valid = 0;
    p_src = 100; p_ptr = 100; p_mux = 100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle of the environment: source, parser model, analysed source and sink.
  task automatic step();
    bit s_fire, a_fire, p_fire, m_fire;
    if (!s_axis_tvalid && src_q.size() > 0 && $urandom_range(99) < p_src) begin
      s_axis_tvalid = 1; s_data = src_q[0].data; s_axis_tlast = src_q[0].last;
    end
    parser_tready      = ($urandom_range(99) < p_ptr);
    m_axis_mux_tready  = ($urandom_range(99) < p_mux);
    parser_result_valid = 0;
    parser_result_drop  = 0;
    if (v_pend) begin
      if (v_wait == 0) begin
        parser_result_valid = 1;
        parser_result_drop  = v_drop;
        v_pend = 0;
        if (!v_drop)
          for (int i = 0; i < an_n; i++)
            an_q.push_back(beat_t'{an_base ^ (32'(i) << 28), (i == an_n - 1)});
      end else begin
        v_wait--;
      end
    end
    if (!s_analysed_tvalid && an_q.size() > 0) begin
      s_analysed_tvalid = 1; an_data = an_q[0].data; s_analysed_tlast = an_q[0].last;
    end
    #1;
    s_fire = s_axis_tvalid && s_axis_tready;
    a_fire = s_analysed_tvalid && s_analysed_tready;
    p_fire = parser_tvalid && parser_tready;
    m_fire = m_axis_mux_tvalid && m_axis_mux_tready;
    trace.push_back(int'(state));
    if (m_axis_mux_tvalid) any_mux_valid = 1;
    if (m_fire) obs_q.push_back(beat_t'{(state == 3'd3) ? an_data : s_data, m_axis_mux_tlast});
    if (s_fire && state == 3'd5) drop_beats++;
    if (p_fire) begin
      hdr_sum = hdr_sum + s_data;
      if (parser_tlast && desc_q.size() > 0) begin
        desc_t dsc;
        dsc = desc_q.pop_front();
        v_pend  = !dsc.never;
        v_wait  = dsc.delay;
        v_drop  = !dsc.fwd;
        an_base = hdr_sum;
        an_n    = dsc.n_an;
        hdr_sum = '0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (s_fire) begin void'(src_q.pop_front()); s_axis_tvalid = 0; s_axis_tlast = 0; end
    if (a_fire) begin void'(an_q.pop_front()); s_analysed_tvalid = 0; s_analysed_tlast = 0; end
  endtask

  function automatic bit env_idle();
    return src_q.size() == 0 && !s_axis_tvalid && an_q.size() == 0 && !s_analysed_tvalid &&
           !v_pend && state == 3'd0;
  endfunction

  task automatic run_until_idle(string name, int max_cycles);
    int c;
    c = 0;
    do begin step(); c++; end while (!env_idle() && c < max_cycles);
    checks++;
    if (!env_idle()) begin
      errors++;
      $display("FAIL %s_done: not idle after %0d cycles, state=%0d required state=0", name, c, state);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state, s_axis_tready, parser_tvalid, parser_tlast, s_analysed_tready,
         m_axis_mux_tvalid, m_axis_mux_tlast} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d rdy=%b pv=%b pl=%b ar=%b mv=%b ml=%b required all 0",
               state, s_axis_tready, parser_tvalid, parser_tlast, s_analysed_tready,
               m_axis_mux_tvalid, m_axis_mux_tlast);
    end
    checks++;
    if (stat_pkt_count !== 0 || stat_drop_count !== 0 || stat_timeout !== 0) begin
      errors++;
      $display("FAIL reset_stats: pkt=%0d drop=%0d to=%b required 0 0 0",
               stat_pkt_count, stat_drop_count, stat_timeout);
    end
  endtask

  task automatic test_forward_5beat();
    int exp_tr[$] = '{0, 1, 1, 2, 2, 2, 2, 3, 4, 4, 4};
    int bad;
    do_reset();
    add_packet(5, 1, 3, 0, 1);
    run_until_idle("fwd5", 200);
    bad = -1;
    for (int i = 0; i < exp_tr.size(); i++)
      if (bad < 0 && (i >= trace.size() || trace[i] != exp_tr[i])) bad = i;
    checks++;
    if (bad >= 0 || trace.size() != exp_tr.size()) begin
      errors++;
      $display("FAIL fwd5_trace: index %0d got %0d required %0d (len %0d required %0d)", bad,
               (bad >= 0 && bad < trace.size()) ? trace[bad] : -1,
               (bad >= 0) ? exp_tr[bad] : -1, trace.size(), exp_tr.size());
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL fwd5_len: got %0d beats required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL fwd5_beat%0d: got %h/%b required %h/%b", i, obs_q[i].data, obs_q[i].last,
                 exp_q[i].data, exp_q[i].last);
      end
    end
    checks++;
    if (stat_pkt_count !== 32'(exp_pkt) || stat_drop_count !== 0) begin
      errors++;
      $display("FAIL fwd5_stats: pkt=%0d drop=%0d required %0d 0", stat_pkt_count,
               stat_drop_count, exp_pkt);
    end
  endtask

  task automatic test_single_beat();
    int exp_tr[$] = '{0, 1, 2, 3, 3};
    bit same;
    do_reset();
    add_packet(1, 1, 0, 0, 2);
    run_until_idle("single", 200);
    same = (trace.size() == exp_tr.size());
    for (int i = 0; same && i < exp_tr.size(); i++) if (trace[i] != exp_tr[i]) same = 0;
    checks++;
    if (!same) begin
      errors++;
      $display("FAIL single_trace: got %p required %p", trace, exp_tr);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_len: got %0d beats required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL single_beat%0d: got %h/%b required %h/%b", i, obs_q[i].data,
                 obs_q[i].last, exp_q[i].data, exp_q[i].last);
      end
    end
    checks++;
    if (stat_pkt_count !== 32'(exp_pkt)) begin
      errors++;
      $display("FAIL single_pkt: got %0d required %0d", stat_pkt_count, exp_pkt);
    end
  endtask

  task automatic test_drop();
    do_reset();
    add_packet(6, 0, 2, 0, 1);
    run_until_idle("drop", 200);
    checks++;
    if (drop_beats != 4) begin
      errors++;
      $display("FAIL drop_beats: got %0d required 4", drop_beats);
    end
    checks++;
    if (any_mux_valid) begin
      errors++;
      $display("FAIL drop_mux_valid: got 1 required 0");
    end
    checks++;
    if (stat_drop_count !== 32'(exp_drop) || stat_pkt_count !== 0 || stat_timeout !== 0) begin
      errors++;
      $display("FAIL drop_stats: drop=%0d pkt=%0d to=%b required %0d 0 0", stat_drop_count,
               stat_pkt_count, stat_timeout, exp_drop);
    end
  endtask

  task automatic test_timeout();
    int n_ctl, next_st;
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      if (mode == 0) add_packet(4, 1, 0, 1, 1);   // parser never answers
      else           add_packet(3, 1, CT - 1, 0, 1); // verdict on the last CONTROL cycle
      run_until_idle(mode == 0 ? "timeout" : "late_verdict", 300);
      n_ctl = 0; next_st = -1;
      for (int i = 0; i < trace.size(); i++) begin
        if (trace[i] == 2) n_ctl++;
        else if (n_ctl > 0 && next_st < 0) next_st = trace[i];
      end
      checks++;
      if (n_ctl != CT || next_st != (mode == 0 ? 5 : 3)) begin
        errors++;
        $display("FAIL %s_control: cycles=%0d next=%0d required %0d next=%0d",
                 mode == 0 ? "timeout" : "late_verdict", n_ctl, next_st, CT, mode == 0 ? 5 : 3);
      end
      checks++;
      if (stat_timeout !== exp_timeout || stat_drop_count !== 32'(exp_drop) ||
          stat_pkt_count !== 32'(exp_pkt)) begin
        errors++;
        $display("FAIL %s_stats: to=%b drop=%0d pkt=%0d required %b %0d %0d",
                 mode == 0 ? "timeout" : "late_verdict", stat_timeout, stat_drop_count,
                 stat_pkt_count, exp_timeout, exp_drop, exp_pkt);
      end
      checks++;
      if (obs_q.size() != exp_q.size() || (mode == 0 && drop_beats != 2)) begin
        errors++;
        $display("FAIL %s_beats: mux=%0d dropped=%0d required mux=%0d",
                 mode == 0 ? "timeout" : "late_verdict", obs_q.size(), drop_beats, exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int c;
    do_reset();
    add_packet(3, 1, 0, 0, 1);
    run_until_idle("mid_first", 200);
    checks++;
    if (stat_pkt_count !== 32'd1) begin
      errors++;
      $display("FAIL mid_pre_pkt: got %0d required 1", stat_pkt_count);
    end
    add_packet(8, 1, 0, 0, 1);
    c = 0;
    do begin step(); c++; end while (state != 3'd4 && c < 100);
    step();
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL mid_reach_remain: state=%0d required 4", state);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({state, s_axis_tready, parser_tvalid, s_analysed_tready, m_axis_mux_tvalid,
         m_axis_mux_tlast} !== 8'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: state=%0d rdy=%b pv=%b ar=%b mv=%b ml=%b required all 0",
               state, s_axis_tready, parser_tvalid, s_analysed_tready, m_axis_mux_tvalid,
               m_axis_mux_tlast);
    end
    checks++;
    if (stat_pkt_count !== 0 || stat_drop_count !== 0 || stat_timeout !== 0) begin
      errors++;
      $display("FAIL mid_reset_stats: pkt=%0d drop=%0d to=%b required 0 0 0",
               stat_pkt_count, stat_drop_count, stat_timeout);
    end
    do_reset();
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    p_src = 70; p_ptr = 60; p_mux = 55;
    for (int k = 0; k < 100; k++)
      add_packet($urandom_range(1, 7), ($urandom_range(99) < 70), $urandom_range(0, 5),
                 ($urandom_range(99) < 5), $urandom_range(1, 3));
    run_until_idle("random", 40000);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_len: got %0d beats required %0d", obs_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random_beat%0d: got %h/%b required %h/%b", i, obs_q[i].data,
                   obs_q[i].last, exp_q[i].data, exp_q[i].last);
      end
    end
    checks++;
    if (stat_pkt_count !== 32'(exp_pkt) || stat_drop_count !== 32'(exp_drop)) begin
      errors++;
      $display("FAIL random_stats: pkt=%0d drop=%0d required %0d %0d", stat_pkt_count,
               stat_drop_count, exp_pkt, exp_drop);
    end
    checks++;
    if (stat_pkt_count + stat_drop_count !== 32'd100) begin
      errors++;
      $display("FAIL random_total: got %0d required 100", stat_pkt_count + stat_drop_count);
    end
    checks++;
    if (stat_timeout !== exp_timeout) begin
      errors++;
      $display("FAIL random_timeout_flag: got %b required %b", stat_timeout, exp_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_forward_5beat();
    test_single_beat();
    test_drop();
    test_timeout();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
